// File: rtl/nios2os_timer_scheduler.sv
// Multiplexes one system-timer tick across NUM_CH virtual timer channels.
// A small scan FSM visits one channel per clock after each tick; Avalon-MM slave for control.
module nios2os_timer_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SCAN  = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

    logic [0:0]        state_reg;
    logic [2:0]        idx_reg;
    logic              pending_reg;
    logic [15:0]       missed_reg;
    logic [NUM_CH-1:0] expired_reg;
    logic [NUM_CH-1:0] irq_mask_reg;
    logic [2:0]        sel_reg;
    logic [CNT_W-1:0]  reload_reg [NUM_CH];
    logic [CNT_W-1:0]  count_reg  [NUM_CH];
    logic [NUM_CH-1:0] enable_reg;
    logic [NUM_CH-1:0] periodic_reg;

    logic              wr;
    logic              sel_valid;
    logic              scan_busy;
    logic              last_idx;
    logic              missed_inc;
    logic [NUM_CH-1:0] bus_hit;
    logic [NUM_CH-1:0] proc;
    logic [NUM_CH-1:0] expire_set;
    logic [NUM_CH-1:0] w1c_mask;
    logic [15:0]       readdata_next;
    logic [CNT_W-1:0]  sel_reload;
    logic [CNT_W-1:0]  sel_count;
    logic              sel_enable;
    logic              sel_periodic;

    assign wr         = chipselect & ~write_n;
    assign sel_valid  = ({1'b0, sel_reg} < 4'(NUM_CH));
    assign scan_busy  = (state_reg == ST_SCAN);
    assign last_idx   = (idx_reg == LAST_IDX);
    assign missed_inc = scan_busy & tick & pending_reg;
    assign w1c_mask   = (wr && address == 3'd0) ? writedata[NUM_CH-1:0] : '0;
    assign irq        = |(expired_reg & irq_mask_reg);

    // A bus write to RELOAD/CTRL of the channel under scan suppresses that channel's scan update.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign bus_hit[gi]    = wr && sel_valid && (sel_reg == 3'(gi)) &&
                                    (address == 3'd3 || address == 3'd4);
            assign proc[gi]       = scan_busy && (idx_reg == 3'(gi)) &&
                                    enable_reg[gi] && !bus_hit[gi];
            assign expire_set[gi] = proc[gi] && (count_reg[gi] == CNT_W'(1));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                reload_reg[i] <= '0;
                count_reg[i]  <= '0;
            end
            enable_reg   <= '0;
            periodic_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus_hit[i] && address == 3'd3) begin
                    reload_reg[i] <= writedata[CNT_W-1:0];
                    count_reg[i]  <= writedata[CNT_W-1:0];
                end else if (bus_hit[i] && address == 3'd4) begin
                    enable_reg[i]   <= writedata[0];
                    periodic_reg[i] <= writedata[1];
                end else if (proc[i]) begin
                    if (count_reg[i] > CNT_W'(1)) begin
                        count_reg[i] <= count_reg[i] - CNT_W'(1);
                    end else if (count_reg[i] == CNT_W'(1)) begin
                        if (periodic_reg[i]) begin
                            count_reg[i] <= reload_reg[i];
                        end else begin
                            count_reg[i]  <= '0;
                            enable_reg[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expired_reg  <= '0;
            irq_mask_reg <= '0;
            sel_reg      <= '0;
            missed_reg   <= '0;
        end else begin
            expired_reg <= (expired_reg & ~w1c_mask) | expire_set;
            if (wr && address == 3'd1) begin
                irq_mask_reg <= writedata[NUM_CH-1:0];
            end
            if (wr && address == 3'd2) begin
                sel_reg <= writedata[2:0];
            end
            if (wr && address == 3'd6) begin
                missed_reg <= missed_inc ? 16'd1 : 16'd0;
            end else if (missed_inc && missed_reg != 16'hFFFF) begin
                missed_reg <= missed_reg + 16'd1;
            end
        end
    end

    // On the last slot a tick arriving now is treated like a pending one: rescan from channel 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            pending_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (tick) begin
                        state_reg <= ST_SCAN;
                        idx_reg   <= '0;
                    end
                end
                default: begin
                    if (last_idx) begin
                        idx_reg     <= '0;
                        pending_reg <= 1'b0;
                        if (!(pending_reg || tick)) begin
                            state_reg <= ST_IDLE;
                        end
                    end else begin
                        idx_reg <= idx_reg + 3'd1;
                        if (tick) begin
                            pending_reg <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_reload   = '0;
        sel_count    = '0;
        sel_enable   = 1'b0;
        sel_periodic = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_reg == 3'(i)) begin
                sel_reload   = reload_reg[i];
                sel_count    = count_reg[i];
                sel_enable   = enable_reg[i];
                sel_periodic = periodic_reg[i];
            end
        end
        readdata_next = '0;
        case (address)
            3'd0: begin
                readdata_next[NUM_CH-1:0] = expired_reg;
                readdata_next[15]         = scan_busy;
            end
            3'd1: readdata_next[NUM_CH-1:0] = irq_mask_reg;
            3'd2: readdata_next[2:0]        = sel_reg;
            3'd3: readdata_next[CNT_W-1:0]  = sel_reload;
            3'd4: readdata_next[1:0]        = {sel_periodic, sel_enable};
            3'd5: readdata_next[CNT_W-1:0]  = sel_count;
            3'd6: readdata_next             = missed_reg;
            default: readdata_next          = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= readdata_next;
        end
    end

endmodule

// File: tb/tb_nios2os_timer_scheduler.sv
// Bench for nios2os_timer_scheduler: directed scenarios plus random bus/tick traffic,
// each cycle compared against an integer reference model of the channel scheduler.
module tb_nios2os_timer_scheduler;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] last_rd;

    // reference model state
    int m_reload [N];
    int m_count  [N];
    bit m_en     [N];
    bit m_per    [N];
    int m_exp, m_mask, m_sel, m_missed;
    int m_pos;        // -1 when no scan in progress, else channel being visited
    bit m_pending;

    nios2os_timer_scheduler #(.NUM_CH(N), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_reload[i] = 0; m_count[i] = 0; m_en[i] = 0; m_per[i] = 0;
        end
        m_exp = 0; m_mask = 0; m_sel = 0; m_missed = 0; m_pos = -1; m_pending = 0;
    endfunction

    function automatic int model_read(input int a);
        case (a)
            0: return ((m_pos >= 0) ? 32'h8000 : 0) | m_exp;
            1: return m_mask;
            2: return m_sel;
            3: return (m_sel < N) ? m_reload[m_sel] : 0;
            4: return (m_sel < N) ? (int'(m_en[m_sel]) | (int'(m_per[m_sel]) << 1)) : 0;
            5: return (m_sel < N) ? m_count[m_sel] : 0;
            6: return m_missed;
            default: return 0;
        endcase
    endfunction

    function automatic bit model_irq();
        return (m_exp & m_mask) != 0;
    endfunction

    function automatic void model_step(input bit t, input bit w, input int a, input int d);
        int bus_ch;
        int c;
        int new_exp;
        bit inc;
        bus_ch  = (w && (a == 3 || a == 4) && m_sel < N) ? m_sel : -1;
        new_exp = 0;
        if (m_pos >= 0) begin
            c = m_pos;
            if (m_en[c] && c != bus_ch) begin
                if (m_count[c] > 1) m_count[c]--;
                else if (m_count[c] == 1) begin
                    new_exp = 1 << c;
                    if (m_per[c]) m_count[c] = m_reload[c];
                    else begin m_count[c] = 0; m_en[c] = 0; end
                end
            end
        end
        if (bus_ch >= 0 && a == 3) begin m_reload[bus_ch] = d; m_count[bus_ch] = d; end
        if (bus_ch >= 0 && a == 4) begin m_en[bus_ch] = d[0]; m_per[bus_ch] = d[1]; end
        m_exp = (m_exp & ~((w && a == 0) ? (d & 15) : 0)) | new_exp;
        if (w && a == 1) m_mask = d & 15;
        if (w && a == 2) m_sel = d & 7;
        inc = (m_pos >= 0) && t && m_pending;
        if (w && a == 6) m_missed = inc ? 1 : 0;
        else if (inc && m_missed < 65535) m_missed++;
        if (m_pos < 0) begin
            if (t) m_pos = 0;
        end else if (m_pos == N - 1) begin
            m_pos = (m_pending || t) ? 0 : -1;
            m_pending = 0;
        end else begin
            m_pos++;
            if (t) m_pending = 1;
        end
    endfunction

    task automatic do_cycle(input bit t, input bit cs, input bit wn,
                            input logic [2:0] a, input logic [15:0] d);
        int exp_rd;
        tick = t; chipselect = cs; write_n = wn; address = a; writedata = d;
        exp_rd = model_read(int'(a));
        model_step(t, cs && !wn, int'(a), int'(d));
        @(posedge clk); #1;
        last_rd = readdata;
        chk("readdata", readdata, exp_rd);
        chk("irq", irq, model_irq());
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        do_cycle(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic bus_read(input logic [2:0] a);
        do_cycle(1'b0, 1'b1, 1'b1, a, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b1, 3'd0, 16'h0);
    endtask

    task automatic pulse_tick();
        do_cycle(1'b1, 1'b0, 1'b1, 3'd0, 16'h0);
    endtask

    initial begin
        int events;
        int busy_cnt;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdata", readdata, 16'h0);
        chk("reset_irq", irq, 1'b0);
        reset_n = 1'b1;

        // reset state
        bus_read(3'd0);
        chk("reset_status", last_rd, 16'h0);
        bus_read(3'd5);
        chk("reset_count", last_rd, 16'h0);

        // one-shot channel 0
        bus_write(3'd2, 16'd0);
        bus_write(3'd3, 16'd3);
        bus_write(3'd4, 16'd1);
        bus_write(3'd1, 16'd1);
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            idle(9);
        end
        chk("oneshot_irq", irq, 1'b1);
        bus_read(3'd0);
        chk("oneshot_status", last_rd, 16'h0001);
        bus_read(3'd4);
        chk("oneshot_ctrl", last_rd, 16'h0);
        bus_read(3'd5);
        chk("oneshot_count", last_rd, 16'h0);
        bus_write(3'd0, 16'd1);
        chk("oneshot_irq_clr", irq, 1'b0);

        // periodic channel 1
        bus_write(3'd2, 16'd1);
        bus_write(3'd3, 16'd2);
        bus_write(3'd4, 16'd3);
        events = 0;
        for (int k = 1; k <= 6; k++) begin
            pulse_tick();
            idle(6);
            bus_read(3'd0);
            chk("periodic_expiry", last_rd[1], (k % 2 == 0));
            if (last_rd[1]) events++;
            bus_write(3'd0, 16'h0002);
            bus_read(3'd5);
            chk("periodic_count", last_rd, (k % 2 == 0) ? 16'd2 : 16'd1);
        end
        chk("periodic_events", events, 3);
        bus_write(3'd4, 16'd0);

        // tick overrun
        busy_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            do_cycle(1'b1, 1'b1, 1'b1, 3'd0, 16'h0);
            busy_cnt += int'(last_rd[15]);
        end
        for (int k = 0; k < 10; k++) begin
            bus_read(3'd0);
            busy_cnt += int'(last_rd[15]);
        end
        chk("overrun_scan_cycles", busy_cnt, 8);
        bus_read(3'd6);
        chk("overrun_missed", last_rd, 16'd1);
        bus_write(3'd6, 16'd0);
        bus_read(3'd6);
        chk("missed_clear", last_rd, 16'd0);

        // collision: expiry vs W1C of the same bit
        bus_write(3'd2, 16'd2);
        bus_write(3'd3, 16'd1);
        bus_write(3'd4, 16'd1);
        pulse_tick();
        idle(2);
        bus_write(3'd0, 16'h0004);
        bus_read(3'd0);
        chk("collide_w1c", last_rd[2], 1'b1);
        bus_write(3'd0, 16'h0004);
        // collision: RELOAD write during the channel's scan slot
        bus_write(3'd3, 16'd5);
        bus_write(3'd4, 16'd1);
        pulse_tick();
        idle(2);
        bus_write(3'd3, 16'd9);
        idle(3);
        bus_read(3'd5);
        chk("collide_reload", last_rd, 16'd9);
        bus_write(3'd4, 16'd0);

        // asynchronous reset mid-scan
        bus_write(3'd2, 16'd0);
        bus_write(3'd3, 16'd5);
        bus_write(3'd4, 16'd1);
        for (int k = 0; k < 3; k++) pulse_tick();
        idle(3);
        reset_n = 1'b0;
        tick = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
        #2;
        chk("async_rst_readdata", readdata, 16'h0);
        chk("async_rst_irq", irq, 1'b0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_read(3'd5);
        chk("rst_count", last_rd, 16'd0);
        bus_read(3'd0);
        chk("rst_busy", last_rd[15], 1'b0);
        bus_read(3'd6);
        chk("rst_missed", last_rd, 16'd0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            bit t, cs, wn;
            logic [2:0] a;
            logic [15:0] d;
            t  = ($urandom_range(0, 3) == 0);
            cs = ($urandom_range(0, 2) == 0);
            wn = ($urandom_range(0, 1) == 0);
            a  = 3'($urandom_range(0, 7));
            if (a == 3'd3) d = 16'($urandom_range(0, 4));
            else if (a == 3'd2) d = 16'($urandom_range(0, 5));
            else d = 16'($urandom);
            do_cycle(t, cs, wn, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
